// File: rtl/bcd_pkg.sv
// Shared BCD/binary conversion definitions.
// Used by bcd_to_bin and the planned binary-to-BCD block.
package bcd_pkg;

  localparam int BCD_WIDTH_DEF = 32;
  localparam int BIN_WIDTH_DEF = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction cell for reverse double dabble.
// A digit of 8 or more after the right shift gets 3 subtracted.
module bcd_digit_adj (
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  always_comb begin
    d_out = d_in;
    if (d_in >= 4'd8) begin
      d_out = d_in - 4'd3;
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Packed BCD to binary converter, one reverse double dabble step per clock.
// Digits above 9 are rejected with err and a zero result.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int BCD_WIDTH = BCD_WIDTH_DEF,
  parameter int BIN_WIDTH = BIN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BCD_WIDTH-1:0] bcd_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_WIDTH-1:0] bin_out,
  output logic                 err
);

  localparam int NDIG = BCD_WIDTH / 4;
  localparam int CW   = $clog2(BIN_WIDTH + 1);

  state_t               state_q, state_d;
  logic [BCD_WIDTH-1:0] bcd_q, bcd_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [BCD_WIDTH-1:0] bcd_sh;
  logic [BCD_WIDTH-1:0] bcd_adj;
  logic [NDIG-1:0]      bad_dig;
  logic                 last_step;

  // The BCD LSB falls into the top of the binary accumulator.
  assign bcd_sh = {1'b0, bcd_q[BCD_WIDTH-1:1]};

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .d_in  (bcd_sh[4*g +: 4]),
      .d_out (bcd_adj[4*g +: 4])
    );
    assign bad_dig[g] = (bcd_in[4*g +: 4] > 4'd9);
  end

  assign last_step = (cnt_q == CW'(BIN_WIDTH - 1));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bin_out   = bin_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          bin_d = '0;
          if (|bad_dig) begin
            bcd_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            bcd_d   = bcd_in;
            err_d   = 1'b0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        bcd_d = bcd_adj;
        bin_d = {bcd_q[0], bin_q[BIN_WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed-table and randomized checks for bcd_to_bin.
// Expected values are hand-computed or derived from a decimal model.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] bcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] bin_out;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_to_bin dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  typedef struct {
    logic [31:0] bcd;
    logic [27:0] bin;
    logic        err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] dec(input logic [31:0] b);
    logic [27:0] v;
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      v = v * 28'd10 + 28'(b[4*i +: 4]);
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_bcd();
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return b;
  endfunction

  // Called at the negedge just after the accept edge.
  task automatic finish_one(input logic [27:0] exp_bin, input logic exp_err,
                            input bit hold);
    int k;
    k = 0;
    while (!out_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, exp_err ? 0 : 28);
    chk("bin", {4'h0, bin_out}, {4'h0, exp_bin});
    chk("err", {31'h0, err}, {31'h0, exp_err});
    chk("in_ready_done", {31'h0, in_ready}, 0);
    if (hold) begin
      repeat (10) begin
        @(negedge clk);
        chk("hold_bin", {4'h0, bin_out}, {4'h0, exp_bin});
        chk("hold_in_ready", {31'h0, in_ready}, 0);
        chk("hold_out_valid", {31'h0, out_valid}, 1);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("back_idle", {31'h0, in_ready}, 1);
    chk("out_valid_low", {31'h0, out_valid}, 0);
  endtask

  task automatic run_one(input logic [31:0] bcd, input logic [27:0] exp_bin,
                         input logic exp_err, input bit hold);
    @(negedge clk);
    chk("in_ready_idle", {31'h0, in_ready}, 1);
    in_valid  = 1'b1;
    bcd_in    = bcd;
    out_ready = !hold;
    @(negedge clk);
    in_valid = 1'b0;
    bcd_in   = ~bcd;
    finish_one(exp_bin, exp_err, hold);
  endtask

  initial begin
    int n_acc, n_got, cyc;
    logic [27:0] q[$];

    tbl[0]  = '{32'h0000_0000, 28'h0000000, 1'b0};
    tbl[1]  = '{32'h9999_9999, 28'h5F5E0FF, 1'b0};
    tbl[2]  = '{32'h0000_0001, 28'h0000001, 1'b0};
    tbl[3]  = '{32'h0000_0010, 28'h000000A, 1'b0};
    tbl[4]  = '{32'h0000_0042, 28'h000002A, 1'b0};
    tbl[5]  = '{32'h0000_5678, 28'h000162E, 1'b0};
    tbl[6]  = '{32'h1234_5678, 28'h0BC614E, 1'b0};
    tbl[7]  = '{32'h8000_0000, 28'h4C4B400, 1'b0};
    tbl[8]  = '{32'h0000_A000, 28'h0000000, 1'b1};
    tbl[9]  = '{32'h0000_000F, 28'h0000000, 1'b1};
    tbl[10] = '{32'hF000_0000, 28'h0000000, 1'b1};
    tbl[11] = '{32'h9999_999A, 28'h0000000, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = '0;
    #3;
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_bin", {4'h0, bin_out}, 0);
    chk("rst_err", {31'h0, err}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_one(tbl[i].bcd, tbl[i].bin, tbl[i].err, 1'b0);
    end

    run_one(32'h0000_1234, 28'h00004D2, 1'b0, 1'b1);

    // Reset in the middle of a conversion, then accept right after release.
    @(negedge clk);
    in_valid  = 1'b1;
    bcd_in    = 32'h0000_5678;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'h0, in_ready}, 1);
    chk("mid_rst_out_valid", {31'h0, out_valid}, 0);
    chk("mid_rst_bin", {4'h0, bin_out}, 0);
    chk("mid_rst_err", {31'h0, err}, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    bcd_in   = 32'h0000_0042;
    @(negedge clk);
    in_valid = 1'b0;
    bcd_in   = '0;
    chk("accept_after_rst", {31'h0, in_ready}, 0);
    finish_one(28'h000002A, 1'b0, 1'b0);

    n_acc = 0;
    n_got = 0;
    cyc   = 0;
    while (n_got < 20 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (n_acc < 20) begin
        in_valid = 1'($urandom_range(0, 1));
        bcd_in   = rand_bcd();
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        q.push_back(dec(bcd_in));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_duplicate", 1, 0);
        end else begin
          chk("rnd_bin", {4'h0, bin_out}, {4'h0, q.pop_front()});
        end
        chk("rnd_err", {31'h0, err}, 0);
        n_got++;
      end
    end
    chk("rnd_results", n_got, 20);
    chk("rnd_drain", q.size(), 0);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
